// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and drain into idle slots; a busy scoreboard flags hazards.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_wn,
    input  logic [31:0]   pipe_wd,
    input  logic          mdu_valid,
    input  logic [4:0]    mdu_wn,
    input  logic [31:0]   mdu_wd,
    output logic          mdu_ready,
    input  logic          issue_valid,
    input  logic [4:0]    issue_wn,
    input  logic [4:0]    chk_rs,
    input  logic [4:0]    chk_rt,
    output logic          src_stall,
    output logic          issue_stall,
    output logic          RegWrite,
    output logic [4:0]    WN,
    output logic [31:0]   WD,
    output logic [CW-1:0] q_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    fifo_wn [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   busy_reg, busy_next;

    logic          pipe_busy;
    logic          push;
    logic          pop;
    logic [4:0]    head_wn;
    logic [31:0]   head_wd;

    // A pipeline write to r0 leaves the port slot free for the FIFO.
    assign pipe_busy = pipe_we && (pipe_wn != 5'd0);
    assign head_wn   = fifo_wn[head_reg];
    assign head_wd   = fifo_wd[head_reg];

    // Ready depends only on the registered count, so a full FIFO stays closed
    // even in a cycle where the head drains.
    assign mdu_ready = (count_reg < CW'(DEPTH));
    assign push      = mdu_valid && mdu_ready;
    assign pop       = !rst && !pipe_busy && (count_reg != '0);
    assign q_count   = count_reg;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop) begin
            head_next = head_reg + PW'(1);
        end
        if (push) begin
            tail_next = tail_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Scoreboard: a set from a new issue overrides a clear from a drain.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit       = issue_valid && (issue_wn == 5'(gi));
            assign clr_bit       = pop && (head_wn == 5'(gi));
            assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
        end
    endgenerate

    assign src_stall   = busy_reg[chk_rs] | busy_reg[chk_rt];
    assign issue_stall = busy_reg[issue_wn];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn[tail_reg] <= mdu_wn;
            fifo_wd[tail_reg] <= mdu_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        RegWrite = 1'b0;
        WN       = 5'd0;
        WD       = 32'd0;
        if (!rst) begin
            if (pipe_busy) begin
                RegWrite = 1'b1;
                WN       = pipe_wn;
                WD       = pipe_wd;
            end else if (count_reg != '0) begin
                // Results destined for r0 still drain, but never write.
                RegWrite = (head_wn != 5'd0);
                WN       = head_wn;
                WD       = head_wd;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-by-cycle vector table plus a
// hand-written full-FIFO drain sequence.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_wn;
    logic [31:0] pipe_wd;
    logic        mdu_valid;
    logic [4:0]  mdu_wn;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_wn;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        src_stall;
    logic        issue_stall;
    logic        RegWrite;
    logic [4:0]  WN;
    logic [31:0] WD;
    logic [1:0]  q_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2), .CW(2)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_wd(pipe_wd),
        .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_wn(issue_wn),
        .chk_rs(chk_rs), .chk_rt(chk_rt),
        .src_stall(src_stall), .issue_stall(issue_stall),
        .RegWrite(RegWrite), .WN(WN), .WD(WD), .q_count(q_count)
    );

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  pwn;
        logic [31:0] pwd;
        logic        mv;
        logic [4:0]  mwn;
        logic [31:0] mwd;
        logic        iv;
        logic [4:0]  iwn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        erw;
        logic [4:0]  ewn;
        logic [31:0] ewd;
        logic        erdy;
        logic [1:0]  ecnt;
        logic        esrc;
        logic        eiss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, input logic pwe, input logic [4:0] pwn, input logic [31:0] pwd,
        input logic mv, input logic [4:0] mwn, input logic [31:0] mwd,
        input logic iv, input logic [4:0] iwn, input logic [4:0] rs, input logic [4:0] rt,
        input logic erw, input logic [4:0] ewn, input logic [31:0] ewd,
        input logic erdy, input logic [1:0] ecnt, input logic esrc, input logic eiss);
        vec_t v;
        v.rst = rst_i; v.pwe = pwe; v.pwn = pwn; v.pwd = pwd;
        v.mv = mv; v.mwn = mwn; v.mwd = mwd;
        v.iv = iv; v.iwn = iwn; v.rs = rs; v.rt = rt;
        v.erw = erw; v.ewn = ewn; v.ewd = ewd;
        v.erdy = erdy; v.ecnt = ecnt; v.esrc = esrc; v.eiss = eiss;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; pipe_we = 1'b0; pipe_wn = 5'd0; pipe_wd = 32'd0;
        mdu_valid = 1'b0; mdu_wn = 5'd0; mdu_wd = 32'd0;
        issue_valid = 1'b0; issue_wn = 5'd0; chk_rs = 5'd0; chk_rt = 5'd0;
    endtask

    initial begin
        //          rst pwe pwn  pwd     mv mwn  mwd       iv iwn rs  rt   erw ewn ewd       rdy cnt src iss
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // reset state
        vecs.push_back(mk(0, 1, 5,  32'h11, 0, 0,  32'h0,    0, 0,  0,  0,   1, 5,  32'h11,   1, 0, 0, 0)); // pipe write
        vecs.push_back(mk(0, 1, 0,  32'h22, 0, 0,  32'h0,    0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // r0 write is idle
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    1, 8,  8,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // issue r8
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 8,  32'hABCD, 0, 0,  8,  0,   0, 0,  32'h0,    1, 0, 1, 0)); // push, no bypass
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  8,  0,   1, 8,  32'hABCD, 1, 1, 1, 0)); // drain r8
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  8,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // busy[8] cleared
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    1, 9,  0,  9,   0, 0,  32'h0,    1, 0, 0, 0)); // issue r9
        vecs.push_back(mk(0, 1, 3,  32'h33, 1, 9,  32'h1,    0, 0,  0,  9,   1, 3,  32'h33,   1, 0, 1, 0)); // pipe + push 9
        vecs.push_back(mk(0, 1, 3,  32'h33, 1, 10, 32'h2,    0, 0,  0,  9,   1, 3,  32'h33,   1, 1, 1, 0)); // pipe + push 10
        vecs.push_back(mk(0, 1, 3,  32'h33, 1, 11, 32'h3,    0, 0,  0,  9,   1, 3,  32'h33,   0, 2, 1, 0)); // full, 11 held
        vecs.push_back(mk(0, 1, 3,  32'h33, 1, 11, 32'h3,    0, 0,  0,  9,   1, 3,  32'h33,   0, 2, 1, 0)); // full, 11 held
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 11, 32'h3,    0, 0,  0,  9,   1, 9,  32'h1,    0, 2, 1, 0)); // pop does not reopen
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 11, 32'h3,    0, 0,  0,  9,   1, 10, 32'h2,    1, 1, 0, 0)); // 11 accepted
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   1, 11, 32'h3,    1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 20, 32'h100,  0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // fill to 1
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 21, 32'h101,  0, 0,  0,  0,   1, 20, 32'h100,  1, 1, 0, 0)); // push+pop
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 22, 32'h102,  0, 0,  0,  0,   1, 21, 32'h101,  1, 1, 0, 0)); // push+pop
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 23, 32'h103,  0, 0,  0,  0,   1, 22, 32'h102,  1, 1, 0, 0)); // push+pop, wrapped
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   1, 23, 32'h103,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    1, 12, 0,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // issue r12
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 12, 32'hC0,   0, 12, 0,  0,   0, 0,  32'h0,    1, 0, 0, 1)); // WAW flagged
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    1, 12, 0,  0,   1, 12, 32'hC0,   1, 1, 0, 1)); // clear vs set
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 0,  32'h55,   0, 12, 12, 0,   0, 0,  32'h0,    1, 0, 1, 1)); // set won; push r0
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 12, 12, 0,   0, 0,  32'h0,    1, 1, 1, 1)); // r0 pop, no write
        vecs.push_back(mk(0, 1, 12, 32'h77, 0, 0,  32'h0,    0, 12, 0,  0,   1, 12, 32'h77,   1, 0, 0, 1)); // pipe to busy reg
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 12, 0,  0,   0, 0,  32'h0,    1, 0, 0, 1)); // busy unchanged
        vecs.push_back(mk(0, 0, 0,  32'h0,  1, 7,  32'h70,   1, 7,  12, 0,   0, 0,  32'h0,    1, 0, 1, 0)); // issue r7, push
        vecs.push_back(mk(0, 1, 1,  32'h1,  1, 13, 32'h71,   0, 7,  12, 0,   1, 1,  32'h1,    1, 1, 1, 1)); // push to 2
        vecs.push_back(mk(1, 1, 2,  32'h2,  0, 0,  32'h0,    0, 7,  12, 0,   0, 0,  32'h0,    0, 2, 1, 1)); // rst mid-drain
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 7,  12, 7,   0, 0,  32'h0,    1, 0, 0, 0)); // cleared
        vecs.push_back(mk(0, 0, 0,  32'h0,  0, 0,  32'h0,    0, 0,  0,  0,   0, 0,  32'h0,    1, 0, 0, 0)); // queue discarded

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; pipe_we = vecs[i].pwe; pipe_wn = vecs[i].pwn; pipe_wd = vecs[i].pwd;
            mdu_valid = vecs[i].mv; mdu_wn = vecs[i].mwn; mdu_wd = vecs[i].mwd;
            issue_valid = vecs[i].iv; issue_wn = vecs[i].iwn; chk_rs = vecs[i].rs; chk_rt = vecs[i].rt;
            #2;
            $display("vec %0d: RegWrite=%0b WN=%0d WD=0x%0h q_count=%0d mdu_ready=%0b src_stall=%0b issue_stall=%0b",
                     i, RegWrite, WN, WD, q_count, mdu_ready, src_stall, issue_stall);
            check("RegWrite", i, 32'(RegWrite), 32'(vecs[i].erw));
            if (vecs[i].erw) begin
                check("WN", i, 32'(WN), 32'(vecs[i].ewn));
                check("WD", i, WD, vecs[i].ewd);
            end
            check("mdu_ready", i, 32'(mdu_ready), 32'(vecs[i].erdy));
            check("q_count", i, 32'(q_count), 32'(vecs[i].ecnt));
            check("src_stall", i, 32'(src_stall), 32'(vecs[i].esrc));
            check("issue_stall", i, 32'(issue_stall), 32'(vecs[i].eiss));
        end

        // Full FIFO with a held result, then drain: writes must come out 14, 15, 16.
        begin
            logic [4:0]  exp_wn [3];
            logic [31:0] exp_wd [3];
            int got;
            logic accepted;
            exp_wn[0] = 5'd14; exp_wd[0] = 32'hE1;
            exp_wn[1] = 5'd15; exp_wd[1] = 32'hE2;
            exp_wn[2] = 5'd16; exp_wd[2] = 32'hE3;

            @(negedge clk);
            drive_idle();
            pipe_we = 1'b1; pipe_wn = 5'd3; pipe_wd = 32'h3;
            mdu_valid = 1'b1; mdu_wn = 5'd14; mdu_wd = 32'hE1;
            @(negedge clk);
            mdu_wn = 5'd15; mdu_wd = 32'hE2;
            @(negedge clk);
            mdu_wn = 5'd16; mdu_wd = 32'hE3;
            #2;
            $display("drain: held q_count=%0d mdu_ready=%0b", q_count, mdu_ready);
            check("drain_full_ready", 100, 32'(mdu_ready), 32'd0);
            check("drain_full_count", 100, 32'(q_count), 32'd2);
            @(negedge clk);
            #2;
            check("drain_held_ready", 101, 32'(mdu_ready), 32'd0);

            got = 0;
            accepted = 1'b0;
            for (int c = 0; c < 12 && got < 3; c++) begin
                @(negedge clk);
                pipe_we = 1'b0;
                if (accepted) mdu_valid = 1'b0;
                #2;
                if (RegWrite) begin
                    $display("drain %0d: WN=%0d WD=0x%0h", got, WN, WD);
                    check("drain_wn", 110 + got, 32'(WN), 32'(exp_wn[got]));
                    check("drain_wd", 110 + got, WD, exp_wd[got]);
                    got++;
                end
                if (mdu_valid && mdu_ready) accepted = 1'b1;
            end
            check("drain_count_done", 120, 32'(got), 32'd3);
            @(negedge clk);
            #2;
            check("drain_empty", 121, 32'(q_count), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Arbitrates the single register-file write port (RegWrite/WN/WD) between two sources: the in-order pipeline writeback stage and the multi-cycle mul/div unit (MDU).
- Pipeline writes always win and are never stalled.
- MDU results wait in a small FIFO and drain into idle write-port cycles.
- A 32-bit busy scoreboard tracks registers with outstanding MDU results, so decode can stall on RAW/WAW hazards.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
CW, 2, FIFO count width, equal to log2(DEPTH)+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pipe_we  in  1  pipeline writeback write enable
pipe_wn  in  5  pipeline destination register
pipe_wd  in  32  pipeline write data
mdu_valid  in  1  MDU result valid
mdu_wn  in  5  MDU destination register
mdu_wd  in  32  MDU result data
mdu_ready  out  1  FIFO can accept an MDU result
issue_valid  in  1  MDU op issued this cycle
issue_wn  in  5  destination of the issued MDU op
chk_rs  in  5  decode source register 1
chk_rt  in  5  decode source register 2
src_stall  out  1  decode source is busy (RAW hazard)
issue_stall  out  1  issue_wn is busy (WAW hazard)
RegWrite  out  1  register-file write enable
WN  out  5  register-file write address
WD  out  32  register-file write data
q_count  out  CW  FIFO occupancy

Behaviour:
- Port slot: pipe_busy = pipe_we && (pipe_wn != 0). A pipeline write to r0 counts as an idle slot.
- Write mux (combinational):
  - pipe_busy: RegWrite=1, WN=pipe_wn, WD=pipe_wd.
  - Else, q_count>0: drive the FIFO head. RegWrite = (head_wn != 0), WN=head_wn, WD=head_wd. The head is popped at the clock edge.
  - Else: RegWrite=0; WN and WD are don't-care (drive 0).
  - While rst=1: RegWrite=0.
- Push: on an edge with mdu_valid && mdu_ready, write {mdu_wn, mdu_wd} at the tail. The earliest port write of that result is the next cycle; there is no bypass around the FIFO.
- mdu_ready = (q_count < DEPTH), from registered count only. When the FIFO is full, a same-cycle pop does not reopen mdu_ready.
- Push and pop in the same cycle: q_count unchanged; head and tail pointers both advance and wrap modulo DEPTH.
- mdu_valid while mdu_ready=0: the result is not accepted. The MDU must hold it.
- Scoreboard, busy[31:1] (busy[0] is hard 0):
  - Set: issue_valid && issue_wn!=0 sets busy[issue_wn] at the edge.
  - Clear: popping a head with head_wn!=0 clears busy[head_wn] at the edge.
  - Set and clear of the same register in one cycle: set wins.
- src_stall = busy[chk_rs] | busy[chk_rt] (combinational).
- issue_stall = busy[issue_wn] (combinational). The issuer must not assert issue_valid while issue_stall=1. If it does, busy stays set and no error is flagged.
- A pipeline write to a busy register is written normally and does not alter busy. Ordering is the issuer's responsibility via src_stall/issue_stall.
- Reset (synchronous): q_count=0, head and tail pointers=0, busy=0. This gives mdu_ready=1 and src_stall=issue_stall=0 after the edge. FIFO data is don't-care. A reset mid-drain discards all queued results.
- FIFO order is strictly in order; each entry is written exactly once.

Test Plan:
1. After reset, assert pipe_we=1, pipe_wn=5, pipe_wd=0x11 -> same cycle RegWrite=1, WN=5, WD=0x11; q_count=0; mdu_ready=1.
2. Issue issue_wn=8, then push MDU {8, 0xABCD} while the pipe is idle -> src_stall=1 when chk_rs=8 from the cycle after issue; next cycle RegWrite=1, WN=8, WD=0xABCD; busy[8] clears after that edge.
3. Hold pipe_we=1 (wn=3) for 4 cycles while pushing MDU {9,1}, {10,2}, then {11,3} -> q_count reaches 2; mdu_ready=0 and {11,3} is held; after the pipe goes idle, writes come out in order 9, 10, then 11 once accepted.
4. With the FIFO at count 1, push a new result and pop the head in the same cycle -> q_count stays 1; pointer wrap after 3 such cycles still yields in-order data.
5. Clear busy[12] via pop while issuing issue_wn=12 in the same cycle -> busy[12]=1 afterwards; issue_stall=1 for issue_wn=12. Also push {0, 0x55} -> popped with RegWrite=0.
6. Assert rst with q_count=2 and busy[7]=1 -> next cycle q_count=0, busy=0, RegWrite=0 while rst is high, mdu_ready=1.
